// File: rtl/pipe_pkg.sv
// pipe_pkg: shared write-back select codes and default MEM/WB payload layout
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W = 32;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;
  typedef struct packed {
    logic regwr;
    logic [1:0] memtoreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [ADDR_W-1:0] dst;
    logic [PC_W-1:0] pc;
  } wb_payload_t;
endpackage

// File: rtl/wb_data_sel.sv
// wb_data_sel: write-back value mux (alu / mem / pc+4 link), shared with the regfile write path
module wb_data_sel import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int PC_W = 32
) (
  input  logic [1:0]        memtoreg,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);
  logic [PC_W-1:0] pc4;
  assign pc4 = pc + PC_W'(4);
  // the reserved code 11 falls through to alu
  assign data = memtoreg == MEMTOREG_MEM ? mem :
                memtoreg == MEMTOREG_PC4 ? DATA_W'(pc4) : alu;
endmodule

// File: rtl/mem_wb_elastic.sv
// mem_wb_elastic: MEM/WB register with one-entry skid buffer, flush and forwarding tap
module mem_wb_elastic import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwr,
  input  logic [1:0]        in_memtoreg,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwr,
  output logic [1:0]        out_memtoreg,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [ADDR_W-1:0] out_dst,
  output logic [PC_W-1:0]   out_pc,
  output logic              fwd_en,
  output logic [ADDR_W-1:0] fwd_dst,
  output logic [DATA_W-1:0] fwd_data
);
  typedef struct packed {
    logic regwr;
    logic [1:0] memtoreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [ADDR_W-1:0] dst;
    logic [PC_W-1:0] pc;
  } pl_t;
  pl_t m, s, in_pl;
  logic mv, sv, acc, drn;
  assign in_pl = '{in_regwr, in_memtoreg, in_alu, in_mem, in_dst, in_pc};
  // ready comes straight from the skid flop, so no out_ready path reaches MEM
  assign in_ready = ~sv;
  assign acc = in_valid & in_ready;
  assign drn = mv & out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      m <= '0;
      s <= '0;
      mv <= 1'b0;
      sv <= 1'b0;
    end else if (flush) begin
      mv <= 1'b0;
      sv <= 1'b0;
    end else if (!mv || drn) begin
      if (sv) begin
        m <= s;
        mv <= 1'b1;
        if (acc) s <= in_pl;
        sv <= acc;
      end else begin
        if (acc) m <= in_pl;
        mv <= acc;
      end
    end else if (acc) begin
      s <= in_pl;
      sv <= 1'b1;
    end
  end
  assign out_valid = mv;
  assign out_regwr = m.regwr & mv;
  assign out_memtoreg = m.memtoreg;
  assign out_alu = m.alu;
  assign out_mem = m.mem;
  assign out_dst = m.dst;
  assign out_pc = m.pc;
  assign fwd_en = mv & m.regwr & (m.dst != '0);
  assign fwd_dst = m.dst;
  wb_data_sel #(.DATA_W(DATA_W), .PC_W(PC_W)) u_sel (
    .memtoreg(m.memtoreg),
    .alu(m.alu),
    .mem(m.mem),
    .pc(m.pc),
    .data(fwd_data)
  );
endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb_mem_wb_elastic: directed self-checking bench for mem_wb_elastic
module tb_mem_wb_elastic;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_regwr, out_valid, out_ready, out_regwr, fwd_en;
  logic [1:0] in_memtoreg, out_memtoreg;
  logic [31:0] in_alu, in_mem, in_pc, out_alu, out_mem, out_pc, fwd_data;
  logic [4:0] in_dst, out_dst, fwd_dst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_elastic dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwr(in_regwr),
    .in_memtoreg(in_memtoreg), .in_alu(in_alu), .in_mem(in_mem),
    .in_dst(in_dst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_regwr(out_regwr),
    .out_memtoreg(out_memtoreg), .out_alu(out_alu), .out_mem(out_mem),
    .out_dst(out_dst), .out_pc(out_pc),
    .fwd_en(fwd_en), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] dst, input logic [31:0] pc);
    in_valid = v;
    in_regwr = rw;
    in_memtoreg = mtr;
    in_alu = alu;
    in_mem = mem;
    in_dst = dst;
    in_pc = pc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
    tick;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu", out_alu, 32'h0);
    reset = 1'b0;

    // streaming, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b00, 32'h10 + i, 32'h0, 5'd1, 32'h0);
      tick;
      chk("str_valid", {31'b0, out_valid}, 32'd1);
      chk("str_alu", out_alu, 32'h10 + i);
      chk("str_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick;
    chk("str_empty", {31'b0, out_valid}, 32'd0);

    // backpressure for three cycles
    drive(1'b1, 1'b1, 2'b00, 32'h20, 32'h0, 5'd2, 32'h0);
    tick;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'h21, 32'h0, 5'd2, 32'h0);
    tick;
    chk("bp1_alu", out_alu, 32'h20);
    chk("bp1_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 2'b00, 32'h22, 32'h0, 5'd2, 32'h0);
    tick;
    chk("bp2_alu", out_alu, 32'h20);
    chk("bp2_ready", {31'b0, in_ready}, 32'd0);
    tick;
    chk("bp3_alu", out_alu, 32'h20);
    chk("bp3_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick;
    chk("rel1_alu", out_alu, 32'h21);
    chk("rel1_ready", {31'b0, in_ready}, 32'd1);
    tick;
    chk("rel2_alu", out_alu, 32'h22);
    chk("rel2_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick;
    chk("rel_empty", {31'b0, out_valid}, 32'd0);

    // flush with M and S full plus an incoming beat
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'h30, 32'h0, 5'd3, 32'h0);
    tick;
    drive(1'b1, 1'b1, 2'b00, 32'h31, 32'h0, 5'd3, 32'h0);
    tick;
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 2'b00, 32'h32, 32'h0, 5'd3, 32'h0);
    flush = 1'b1;
    tick;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_regwr", {31'b0, out_regwr}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("fl_dropped", {31'b0, out_valid}, 32'd0);

    // reset mid-stream with both entries full
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 32'h40, 32'h41, 5'd7, 32'h1000);
    tick;
    drive(1'b1, 1'b1, 2'b01, 32'h50, 32'h51, 5'd8, 32'h2000);
    tick;
    chk("rm_full", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rm_valid", {31'b0, out_valid}, 32'd0);
    chk("rm_ready", {31'b0, in_ready}, 32'd1);
    chk("rm_alu", out_alu, 32'h0);
    chk("rm_mem", out_mem, 32'h0);
    chk("rm_pc", out_pc, 32'h0);
    chk("rm_dst", {27'b0, out_dst}, 32'd0);
    chk("rm_mtr", {30'b0, out_memtoreg}, 32'd0);
    chk("rm_regwr", {31'b0, out_regwr}, 32'd0);
    chk("rm_fwd_en", {31'b0, fwd_en}, 32'd0);

    // forwarding tap
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 32'h5, 32'h6, 5'd3, 32'hFFFF_FFFC);
    tick;
    chk("fw_pc4_wrap", fwd_data, 32'h0);
    chk("fw_en", {31'b0, fwd_en}, 32'd1);
    chk("fw_dst", {27'b0, fwd_dst}, 32'd3);
    drive(1'b1, 1'b1, 2'b01, 32'h1, 32'hDEAD_BEEF, 5'd4, 32'h0);
    tick;
    chk("fw_mem", fwd_data, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 2'b00, 32'h1234, 32'h9, 5'd5, 32'h0);
    tick;
    chk("fw_alu", fwd_data, 32'h1234);
    drive(1'b1, 1'b1, 2'b11, 32'h55, 32'h9, 5'd5, 32'h0);
    tick;
    chk("fw_rsvd", fwd_data, 32'h55);
    drive(1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 5'd6, 32'h100);
    tick;
    chk("fw_pc4", fwd_data, 32'h104);
    drive(1'b1, 1'b1, 2'b00, 32'h7, 32'h0, 5'd0, 32'h0);
    tick;
    chk("fw_r0_en", {31'b0, fwd_en}, 32'd0);
    chk("fw_r0_regwr", {31'b0, out_regwr}, 32'd1);
    drive(1'b1, 1'b0, 2'b00, 32'h8, 32'h0, 5'd5, 32'h0);
    tick;
    chk("fw_nowr_en", {31'b0, fwd_en}, 32'd0);
    chk("fw_nowr_regwr", {31'b0, out_regwr}, 32'd0);
    in_valid = 1'b0;
    tick;
    chk("fw_idle_en", {31'b0, fwd_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
